// File: rtl/sl_channel_mux_pkg.sv
// Shared types for the SL channel multiplexer: request modes, FSM state codes
// and the idle line level.
package sl_channel_mux_pkg;

  typedef enum logic [1:0] {
    MODE_OFF = 2'd0,
    MODE_TX  = 2'd1,
    MODE_RX  = 2'd2
  } mode_e;

  typedef logic [1:0] state_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_TX    = 2'd2;
  localparam logic [1:0] ST_RX    = 2'd3;

  localparam logic SL_IDLE_LEVEL = 1'b1;

  // Operating state a mode settles in once the guard interval has elapsed.
  function automatic state_e mode_state(input mode_e m);
    case (m)
      MODE_TX: mode_state = ST_TX;
      MODE_RX: mode_state = ST_RX;
      default: mode_state = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sl_channel_mux_sync.sv
// STAGES-deep single-bit synchroniser; resets and flushes to the idle line level.
module sl_channel_mux_sync
  import sl_channel_mux_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift chain; flush reloads the idle level so no stale level leaks out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {STAGES{SL_IDLE_LEVEL}};
    end else if (flush) begin
      sync_r <= {STAGES{SL_IDLE_LEVEL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/sl_channel_mux.sv
// Routes one SL transmitter/receiver onto one of CHANNELS tri-state line pairs
// with a guarded turnaround. Optional TX readback check: SL_CHANNEL_READBACK_EN.
module sl_channel_mux
  import sl_channel_mux_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int SEL_W        = $clog2(CHANNELS),
  parameter int GUARD_CYCLES = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  mode_e               req_mode,
  input  logic [SEL_W-1:0]    req_ch,
  input  logic                trans_zero,
  input  logic                trans_one,
  output logic                rec_zero,
  output logic                rec_one,
  output logic                busy,
  output logic [SEL_W-1:0]    active_ch,
  output logic                line_err,
  output logic                sel_err,
  output logic                tx_mismatch,
  inout  wire  [CHANNELS-1:0] sl_zeroes_inout,
  inout  wire  [CHANNELS-1:0] sl_ones_inout
);

  localparam int GCNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GCNT_W-1:0] GUARD_LOAD = GCNT_W'(GUARD_CYCLES - 1);
  localparam logic [SEL_W:0]    CH_LIMIT   = (SEL_W+1)'(CHANNELS);

  state_e             state_r, state_nx_s;
  mode_e              mode_r, mode_nx_s;
  logic [SEL_W-1:0]   active_ch_r, ch_nx_s;
  logic [GCNT_W-1:0]  guard_cnt_r, cnt_nx_s;
  logic               req_ready_r, busy_r, drv_en_r, rx_view_r;
  logic               tx_zero_r, tx_one_r;
  logic               line_err_r, sel_err_r;
  logic               clr_flags_s, sel_bad_s;
  logic               rx_zero_s, rx_one_s, sync_zero_s, sync_one_s, flush_s;

  // Next-state decode: requests are taken in every state but GUARD.
  always_comb begin
    state_nx_s  = state_r;
    mode_nx_s   = mode_r;
    ch_nx_s     = active_ch_r;
    cnt_nx_s    = guard_cnt_r;
    clr_flags_s = 1'b0;
    sel_bad_s   = 1'b0;
    if (req_valid && req_ready_r) begin
      clr_flags_s = 1'b1;
      if ({1'b0, req_ch} >= CH_LIMIT) begin
        sel_bad_s  = 1'b1;
        state_nx_s = ST_IDLE;
      end else begin
        case (req_mode)
          MODE_TX, MODE_RX: begin
            if ((mode_state(req_mode) == state_r) && (req_ch == active_ch_r)) begin
              state_nx_s = state_r;
            end else begin
              state_nx_s = ST_GUARD;
              mode_nx_s  = req_mode;
              ch_nx_s    = req_ch;
              cnt_nx_s   = GUARD_LOAD;
            end
          end
          default: state_nx_s = ST_IDLE;
        endcase
      end
    end else begin
      case (state_r)
        ST_GUARD: begin
          if (guard_cnt_r == {GCNT_W{1'b0}}) begin
            state_nx_s = mode_state(mode_r);
          end else begin
            cnt_nx_s = guard_cnt_r - GCNT_W'(1);
          end
        end
        default: state_nx_s = state_r;
      endcase
    end
  end

  // FSM registers plus decoded control/outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      mode_r      <= MODE_OFF;
      active_ch_r <= {SEL_W{1'b0}};
      guard_cnt_r <= {GCNT_W{1'b0}};
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      drv_en_r    <= 1'b0;
      rx_view_r   <= 1'b0;
      tx_zero_r   <= SL_IDLE_LEVEL;
      tx_one_r    <= SL_IDLE_LEVEL;
    end else begin
      state_r     <= state_nx_s;
      mode_r      <= mode_nx_s;
      active_ch_r <= ch_nx_s;
      guard_cnt_r <= cnt_nx_s;
      req_ready_r <= (state_nx_s != ST_GUARD);
      busy_r      <= (state_nx_s != ST_IDLE);
      drv_en_r    <= (state_nx_s == ST_TX);
      rx_view_r   <= (state_nx_s == ST_RX);
      tx_zero_r   <= trans_zero;
      tx_one_r    <= trans_one;
    end
  end

  // Sticky error flags, cleared by any accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_err_r <= 1'b0;
      sel_err_r  <= 1'b0;
    end else if (clr_flags_s) begin
      line_err_r <= 1'b0;
      sel_err_r  <= sel_bad_s;
    end else begin
      line_err_r <= line_err_r | (rx_view_r & ~sync_zero_s & ~sync_one_s);
      sel_err_r  <= sel_err_r;
    end
  end

  // Drivers come straight off flops so an async reset releases them at once.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_drv
    assign sl_zeroes_inout[i] = (drv_en_r && (active_ch_r == SEL_W'(i))) ? tx_zero_r : 1'bz;
    assign sl_ones_inout[i]   = (drv_en_r && (active_ch_r == SEL_W'(i))) ? tx_one_r  : 1'bz;
  end

  // Receive-side selection of the active channel's wires.
  always_comb begin
    rx_zero_s = SL_IDLE_LEVEL;
    rx_one_s  = SL_IDLE_LEVEL;
    for (int i = 0; i < CHANNELS; i++) begin
      if (active_ch_r == SEL_W'(i)) begin
        rx_zero_s = sl_zeroes_inout[i];
        rx_one_s  = sl_ones_inout[i];
      end else begin
        rx_zero_s = rx_zero_s;
        rx_one_s  = rx_one_s;
      end
    end
  end

`ifdef SL_CHANNEL_READBACK_EN
  assign flush_s = ~(rx_view_r | drv_en_r);
`else
  assign flush_s = ~rx_view_r;
`endif

  sl_channel_mux_sync #(.STAGES(SYNC_STAGES)) u_sync_zero (
    .clk(clk), .rst(rst), .flush(flush_s), .d(rx_zero_s), .q(sync_zero_s)
  );

  sl_channel_mux_sync #(.STAGES(SYNC_STAGES)) u_sync_one (
    .clk(clk), .rst(rst), .flush(flush_s), .d(rx_one_s), .q(sync_one_s)
  );

`ifdef SL_CHANNEL_READBACK_EN
  logic [SYNC_STAGES-1:0] exp_zero_r, exp_one_r, chk_vld_r;
  logic                   tx_mismatch_r;

  // Driven level delayed to line up with the synchronised readback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_zero_r    <= {SYNC_STAGES{SL_IDLE_LEVEL}};
      exp_one_r     <= {SYNC_STAGES{SL_IDLE_LEVEL}};
      chk_vld_r     <= {SYNC_STAGES{1'b0}};
      tx_mismatch_r <= 1'b0;
    end else begin
      exp_zero_r <= {exp_zero_r[SYNC_STAGES-2:0], tx_zero_r};
      exp_one_r  <= {exp_one_r[SYNC_STAGES-2:0], tx_one_r};
      chk_vld_r  <= drv_en_r ? {chk_vld_r[SYNC_STAGES-2:0], 1'b1} : {SYNC_STAGES{1'b0}};
      if (clr_flags_s) begin
        tx_mismatch_r <= 1'b0;
      end else begin
        tx_mismatch_r <= tx_mismatch_r | (drv_en_r & chk_vld_r[SYNC_STAGES-1] &
                         ((sync_zero_s != exp_zero_r[SYNC_STAGES-1]) |
                          (sync_one_s  != exp_one_r[SYNC_STAGES-1])));
      end
    end
  end

  assign tx_mismatch = tx_mismatch_r;
`else
  assign tx_mismatch = 1'b0;
`endif

  assign req_ready = req_ready_r;
  assign busy      = busy_r;
  assign active_ch = active_ch_r;
  assign line_err  = line_err_r;
  assign sel_err   = sel_err_r;
  assign rec_zero  = sync_zero_s | ~rx_view_r;
  assign rec_one   = sync_one_s  | ~rx_view_r;

endmodule

// File: tb/tb_sl_channel_mux.sv
// Scoreboard bench for sl_channel_mux: stimulus queues expected observations
// per cycle, a negedge monitor pops and compares them.
module tb_sl_channel_mux;
  import sl_channel_mux_pkg::*;

  // Five channels so that an out-of-range select (5) is representable.
  localparam int CH = 5;
  localparam int SW = 3;

  localparam int S_REC = 0, S_BUSY = 1, S_ACH = 2, S_LERR = 3, S_SERR = 4;
  localparam int S_RDY = 5, S_WZ = 6, S_WO = 7, S_MIS = 8;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       nm;
  } chk_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  mode_e         req_mode = MODE_OFF;
  logic [SW-1:0] req_ch = 3'd0;
  logic          trans_zero = 1'b1;
  logic          trans_one = 1'b1;
  logic          rec_zero, rec_one, busy, line_err, sel_err, tx_mismatch;
  logic [SW-1:0] active_ch;
  wire  [CH-1:0] sl_z;
  wire  [CH-1:0] sl_o;
  logic [CH-1:0] ext_en_z = 5'b0, ext_en_o = 5'b0, ext_z = 5'b0, ext_o = 5'b0;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  chk_t sb_q[$];

  for (genvar i = 0; i < CH; i++) begin : g_line
    pullup (sl_z[i]);
    pullup (sl_o[i]);
    assign sl_z[i] = ext_en_z[i] ? ext_z[i] : 1'bz;
    assign sl_o[i] = ext_en_o[i] ? ext_o[i] : 1'bz;
  end

  sl_channel_mux #(.CHANNELS(CH), .SEL_W(SW), .GUARD_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_ch(req_ch), .trans_zero(trans_zero), .trans_one(trans_one),
    .rec_zero(rec_zero), .rec_one(rec_one), .busy(busy), .active_ch(active_ch),
    .line_err(line_err), .sel_err(sel_err), .tx_mismatch(tx_mismatch),
    .sl_zeroes_inout(sl_z), .sl_ones_inout(sl_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_REC:   observe = {30'd0, rec_zero, rec_one};
      S_BUSY:  observe = {31'd0, busy};
      S_ACH:   observe = {29'd0, active_ch};
      S_LERR:  observe = {31'd0, line_err};
      S_SERR:  observe = {31'd0, sel_err};
      S_RDY:   observe = {31'd0, req_ready};
      S_WZ:    observe = {27'd0, sl_z};
      S_WO:    observe = {27'd0, sl_o};
      S_MIS:   observe = {31'd0, tx_mismatch};
      default: observe = 32'hdead_beef;
    endcase
  endfunction

  // Monitor: compare every queued expectation that falls due this cycle.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        logic [31:0] act;
        act = observe(sb_q[i].sel);
        n_vec = n_vec + 1;
        if (act !== sb_q[i].exp) begin
          n_err = n_err + 1;
          $display("FAIL %s: got %0h expected %0h (cycle %0d)", sb_q[i].nm, act, sb_q[i].exp, cyc);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic expect_at(input int dly, input int sel, input logic [31:0] exp, input string nm);
    chk_t c;
    c.due = cyc + dly;
    c.sel = sel;
    c.exp = exp;
    c.nm  = nm;
    sb_q.push_back(c);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req(input mode_e m, input logic [SW-1:0] ch);
    req_valid = 1'b1;
    req_mode  = m;
    req_ch    = ch;
    tick(1);
    req_valid = 1'b0;
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    expect_at(0, S_RDY,  32'd1,  "reset_ready");
    expect_at(0, S_BUSY, 32'd0,  "reset_busy");
    expect_at(0, S_ACH,  32'd0,  "reset_active_ch");
    expect_at(0, S_REC,  32'd3,  "reset_rec");
    expect_at(0, S_LERR, 32'd0,  "reset_line_err");
    expect_at(0, S_SERR, 32'd0,  "reset_sel_err");
    expect_at(0, S_WZ,   32'h1f, "reset_wires_z");
    expect_at(0, S_MIS,  32'd0,  "reset_mismatch");
    tick(1);

    // TX ch1, trans=01; a request issued during the guard is ignored.
    trans_zero = 1'b0;
    trans_one  = 1'b1;
    do_req(MODE_TX, 3'd1);
    expect_at(0, S_BUSY, 32'd1,  "tx1_busy");
    expect_at(0, S_RDY,  32'd0,  "tx1_guard_ready");
    expect_at(0, S_ACH,  32'd1,  "tx1_active_ch");
    expect_at(0, S_WZ,   32'h1f, "tx1_guard0_wires");
    expect_at(3, S_WZ,   32'h1f, "tx1_guard3_wires");
    expect_at(3, S_RDY,  32'd0,  "tx1_guard3_ready");
    expect_at(4, S_WZ,   32'h1d, "tx1_drive_zeroes");
    expect_at(4, S_WO,   32'h1f, "tx1_drive_ones");
    expect_at(4, S_RDY,  32'd1,  "tx1_ready");
    expect_at(4, S_REC,  32'd3,  "tx1_rec_held");
    expect_at(4, S_MIS,  32'd0,  "tx1_mismatch");
    do_req(MODE_RX, 3'd3);
    tick(4);
    trans_zero = 1'b1;
    trans_one  = 1'b0;
    expect_at(0, S_WZ,  32'h1d, "tx1_latency_old");
    expect_at(0, S_ACH, 32'd1,  "guard_req_ignored");
    expect_at(1, S_WZ,  32'h1f, "tx1_new_zeroes");
    expect_at(1, S_WO,  32'h1d, "tx1_new_ones");
    tick(2);

    // TX ch1 -> RX ch3.
    do_req(MODE_RX, 3'd3);
    expect_at(0, S_WZ,   32'h1f, "rx3_release_z");
    expect_at(0, S_WO,   32'h1f, "rx3_release_o");
    expect_at(0, S_ACH,  32'd3,  "rx3_active_ch");
    expect_at(0, S_RDY,  32'd0,  "rx3_guard_ready");
    tick(4);
    expect_at(0, S_RDY,  32'd1,  "rx3_ready");
    expect_at(0, S_REC,  32'd3,  "rx3_rec_entry");
    ext_en_z[3] = 1'b1; ext_z[3] = 1'b1;
    ext_en_o[3] = 1'b1; ext_o[3] = 1'b0;
    expect_at(0, S_WO,  32'h17, "rx3_ext_wire");
    expect_at(1, S_REC, 32'd3,  "rx3_sync_lat1");
    expect_at(2, S_REC, 32'd2,  "rx3_rec_10");
    tick(3);
    ext_z[3] = 1'b0; ext_o[3] = 1'b1;
    expect_at(1, S_REC,  32'd2, "rx3_rec_hold");
    expect_at(2, S_REC,  32'd1, "rx3_rec_01");
    expect_at(2, S_LERR, 32'd0, "rx3_no_line_err");
    tick(3);
    ext_en_z = 5'b0; ext_en_o = 5'b0;

    // RX ch0 with both wires low: sticky line_err.
    do_req(MODE_RX, 3'd0);
    ext_en_z[0] = 1'b1; ext_z[0] = 1'b0;
    ext_en_o[0] = 1'b1; ext_o[0] = 1'b0;
    expect_at(0, S_REC,  32'd3, "rx0_guard_rec");
    expect_at(5, S_REC,  32'd3, "rx0_flushed");
    expect_at(6, S_REC,  32'd0, "rx0_rec_00");
    expect_at(6, S_LERR, 32'd0, "rx0_line_err_pre");
    expect_at(7, S_LERR, 32'd1, "rx0_line_err_set");
    tick(7);
    ext_en_z = 5'b0; ext_en_o = 5'b0;
    expect_at(2, S_REC,  32'd3, "rx0_rec_idle");
    expect_at(3, S_LERR, 32'd1, "rx0_line_err_sticky");
    tick(3);
    do_req(MODE_RX, 3'd0);
    expect_at(0, S_LERR, 32'd0, "noop_clears_line_err");
    expect_at(0, S_BUSY, 32'd1, "noop_busy");
    expect_at(0, S_RDY,  32'd1, "noop_ready");
    expect_at(1, S_REC,  32'd3, "noop_rec");
    tick(2);
    do_req(MODE_OFF, 3'd0);
    expect_at(0, S_BUSY, 32'd0, "off_busy");
    expect_at(0, S_RDY,  32'd1, "off_ready");
    tick(1);

    // Out-of-range select, then TX ch2 clears it.
    do_req(MODE_TX, 3'd5);
    expect_at(0, S_SERR, 32'd1, "sel_err_set");
    expect_at(0, S_BUSY, 32'd0, "sel_err_idle");
    expect_at(0, S_ACH,  32'd0, "sel_err_ch_kept");
    expect_at(2, S_SERR, 32'd1, "sel_err_sticky");
    tick(2);
    trans_zero = 1'b0;
    trans_one  = 1'b1;
    do_req(MODE_TX, 3'd2);
    expect_at(0, S_SERR, 32'd0,  "sel_err_cleared");
    expect_at(0, S_BUSY, 32'd1,  "tx2_busy");
    expect_at(3, S_WZ,   32'h1f, "tx2_guard_wires");
    expect_at(4, S_WZ,   32'h1b, "tx2_drive_zeroes");
    tick(6);

    // Async reset mid-TX: released before any further clock edge.
    #1;
    expect_at(0, S_WZ,   32'h1f, "areset_wires");
    expect_at(0, S_REC,  32'd3,  "areset_rec");
    expect_at(0, S_BUSY, 32'd0,  "areset_busy");
    expect_at(0, S_RDY,  32'd1,  "areset_ready");
    expect_at(0, S_ACH,  32'd0,  "areset_active_ch");
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);

`ifdef SL_CHANNEL_READBACK_EN
    // TX ch0 driving zeroes=0 while the line is held high externally.
    trans_zero = 1'b0;
    trans_one  = 1'b1;
    do_req(MODE_TX, 3'd0);
    tick(8);
    expect_at(0, S_MIS, 32'd0, "rb_clean");
    ext_en_z[0] = 1'b1; ext_z[0] = 1'b1;
    expect_at(2, S_MIS, 32'd0, "rb_lat");
    expect_at(3, S_MIS, 32'd1, "rb_mismatch");
    expect_at(5, S_MIS, 32'd1, "rb_sticky");
    tick(5);
    ext_en_z = 5'b0;
`endif

    for (int k = 0; k < 50 && sb_q.size() != 0; k++) tick(1);
    if (sb_q.size() != 0) begin
      foreach (sb_q[i]) $display("FAIL %s: never sampled, expected %0h", sb_q[i].nm, sb_q[i].exp);
      n_vec = n_vec + sb_q.size();
      n_err = n_err + sb_q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
